// File: rtl/debounce_or3_pkg.sv
// Shared constants and helpers for the three-channel debounced OR.
package debounce_or3_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int NUM_CH              = 3;

  // Counter width that can hold 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_or3_if.sv
// Raw channel inputs, debounced outputs and the event handshake.
interface debounce_or3_if;
  import debounce_or3_pkg::*;

  logic                a;
  logic                b;
  logic                c;
  logic                evt_ack;
  logic                y;
  logic [NUM_CH-1:0]   src;
  logic                y_rise;
  logic                evt_valid;
  logic [NUM_CH-1:0]   evt_src;

  modport master (
    output a, b, c, evt_ack,
    input  y, src, y_rise, evt_valid, evt_src
  );

  modport slave (
    input  a, b, c, evt_ack,
    output y, src, y_rise, evt_valid, evt_src
  );

endinterface

// File: rtl/debounce_or3_bit.sv
// One channel: two-flop synchronizer followed by a consecutive-difference debounce counter.
module debounce_bit
  import debounce_or3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic s_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s_d   = s_q;
    cnt_d = '0;
    if (sync2_q != s_q) begin
      if (cnt_q == CNT_MAX) begin
        s_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_o = s_q;

endmodule

// File: rtl/debounce_or3.sv
// Three debounced channels ORed together, with rising-edge detect and a sticky event latch.
module debounce_or3
  import debounce_or3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  debounce_or3_if.slave  bus
);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] s;
  logic              y;
  logic              y_rise;
  logic              y_q;
  logic              evt_valid_q, evt_valid_d;
  logic [NUM_CH-1:0] evt_src_q, evt_src_d;

  assign raw = {bus.c, bus.b, bus.a};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .raw_i (raw[ch]),
      .s_o   (s[ch])
    );
  end

  // Outputs depend only on the stable levels, never on the raw pins.
  assign y      = |s;
  assign y_rise = y & ~y_q;

  // A new event takes priority over a simultaneous acknowledge.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_src_d   = evt_src_q;
    if (y_rise) begin
      evt_valid_d = 1'b1;
      evt_src_d   = s;
    end else if (bus.evt_ack) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q         <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_src_q   <= '0;
    end else begin
      y_q         <= y;
      evt_valid_q <= evt_valid_d;
      evt_src_q   <= evt_src_d;
    end
  end

  assign bus.y         = y;
  assign bus.src       = s;
  assign bus.y_rise    = y_rise;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_src   = evt_src_q;

endmodule

// File: tb/tb_debounce_or3.sv
// Directed and random stimulus for debounce_or3 checked against a window-based reference model.
module tb_debounce_or3;
  import debounce_or3_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ta = 1'b0, tb = 1'b0, tc = 1'b0, tack = 1'b0;

  int errors = 0;
  int checks = 0;

  debounce_or3_if bus ();

  assign bus.a       = ta;
  assign bus.b       = tb;
  assign bus.c       = tc;
  assign bus.evt_ack = tack;

  debounce_or3 #(.DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a level flips once the last D synchronized samples since
  // its previous flip all disagreed with it.
  logic [2:0] m_s;
  logic       m_y_q;
  logic       m_ev;
  logic [2:0] m_evsrc;
  logic [2:0] hist[$];
  logic [2:0] diffs[$];
  int         last_flip[3];

  task automatic model_reset();
    m_s = 3'b000;
    m_y_q = 1'b0;
    m_ev = 1'b0;
    m_evsrc = 3'b000;
    hist.delete();
    diffs.delete();
    for (int ch = 0; ch < 3; ch++) last_flip[ch] = 0;
  endtask

  task automatic model_edge(input logic [2:0] raw, input logic ack);
    logic [2:0] s2;
    logic       y_pre;
    logic       rise_pre;
    bit         all1;
    y_pre    = |m_s;
    rise_pre = y_pre & ~m_y_q;
    if (rise_pre) begin
      m_ev    = 1'b1;
      m_evsrc = m_s;
    end else if (ack) begin
      m_ev = 1'b0;
    end
    m_y_q = y_pre;
    s2 = (hist.size() >= 2) ? hist[hist.size()-2] : 3'b000;
    hist.push_back(raw);
    diffs.push_back(s2 ^ m_s);
    for (int ch = 0; ch < 3; ch++) begin
      if (diffs.size() - last_flip[ch] >= D) begin
        all1 = 1'b1;
        for (int k = 1; k <= D; k++)
          if (!diffs[diffs.size()-k][ch]) all1 = 1'b0;
        if (all1) begin
          m_s[ch]       = s2[ch];
          last_flip[ch] = diffs.size();
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("y",         {7'd0, bus.y},         {7'd0, |m_s});
    check("src",       {5'd0, bus.src},       {5'd0, m_s});
    check("y_rise",    {7'd0, bus.y_rise},    {7'd0, (|m_s) & ~m_y_q});
    check("evt_valid", {7'd0, bus.evt_valid}, {7'd0, m_ev});
    check("evt_src",   {5'd0, bus.evt_src},   {5'd0, m_evsrc});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge({tc, tb, ta}, tack);
    #2;
    check_model();
  endtask

  // Called mid-cycle; asserts reset, checks the immediate clear, releases on the falling edge.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_y",         {7'd0, bus.y},         8'd0);
    check("rst_src",       {5'd0, bus.src},       8'd0);
    check("rst_y_rise",    {7'd0, bus.y_rise},    8'd0);
    check("rst_evt_valid", {7'd0, bus.evt_valid}, 8'd0);
    check("rst_evt_src",   {5'd0, bus.evt_src},   8'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int first_y;
    int rises;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    do_reset();

    // Single channel rise: y appears after edge 5 counting from edge 0.
    ta = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) check("a_lat_edge4_y", {7'd0, bus.y}, 8'd0);
      if (i == 5) begin
        check("a_lat_edge5_y",      {7'd0, bus.y},      8'd1);
        check("a_lat_edge5_src",    {5'd0, bus.src},    8'h01);
        check("a_lat_edge5_y_rise", {7'd0, bus.y_rise}, 8'd1);
      end
      if (i == 6) begin
        check("a_edge6_y_rise",  {7'd0, bus.y_rise},    8'd0);
        check("a_edge6_evt",     {7'd0, bus.evt_valid}, 8'd1);
        check("a_edge6_evt_src", {5'd0, bus.evt_src},   8'h01);
      end
    end

    // Short pulse on b must be rejected.
    ta = 1'b0;
    do_reset();
    tb = 1'b1;
    repeat (3) tick();
    tb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("b_pulse_y", {7'd0, bus.y | bus.evt_valid}, 8'd0);
    end

    // Bouncing a, then hold.
    do_reset();
    ta = 1'b1; tick();
    ta = 1'b0; tick();
    ta = 1'b1; tick();
    ta = 1'b0; tick();
    ta = 1'b1;
    first_y = -1;
    rises = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.y_rise) rises++;
      if (bus.y === 1'b1 && first_y < 0) first_y = i;
    end
    check("bounce_first_y", first_y[7:0], 8'(D + 2));
    check("bounce_rises",   rises[7:0],   8'd1);

    // a and c together, ack on the y_rise cycle and on the cycle after.
    ta = 1'b0;
    do_reset();
    ta = 1'b1;
    tc = 1'b1;
    repeat (6) tick();
    check("ac_y_rise", {7'd0, bus.y_rise}, 8'd1);
    tack = 1'b1;
    tick();
    check("ac_ack_same_valid", {7'd0, bus.evt_valid}, 8'd1);
    check("ac_evt_src",        {5'd0, bus.evt_src},   8'h05);
    tick();
    check("ac_ack_next_valid", {7'd0, bus.evt_valid}, 8'd0);
    check("ac_ack_next_src",   {5'd0, bus.evt_src},   8'h05);
    tack = 1'b0;
    tick();

    // Reset in the middle of a debounce run.
    ta = 1'b0;
    tc = 1'b0;
    do_reset();
    ta = 1'b1;
    repeat (4) tick();
    do_reset();
    first_y = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.y === 1'b1 && first_y < 0) first_y = i;
    end
    check("mid_rst_first_y", first_y[7:0], 8'd6);

    // Random stimulus with held levels of random length and occasional glitches.
    ta = 1'b0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) ta = ~ta;
      if ($urandom_range(0, 6) == 0) tb = ~tb;
      if ($urandom_range(0, 7) == 0) tc = ~tc;
      tack = ($urandom_range(0, 3) == 0);
      tick();
      if (i == 300) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
